// File: rtl/fifo_pkt_pkg.sv
// Shared definitions for the packet writer and the read-side frame parser.
package fifo_pkt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAY,
    CSUM,
    DONE
  } pkt_state_t;

  localparam logic [3:0] HDR_TAG = 4'hA;
  localparam int         MAX_LEN = 16;

  // A length field of zero encodes the maximum payload of MAX_LEN bytes.
  function automatic logic [4:0] decode_len(input logic [3:0] len_field);
    return (len_field == 4'd0) ? 5'(MAX_LEN) : {1'b0, len_field};
  endfunction

endpackage

// File: rtl/fifo_pkt_writer.sv
// Frames a payload burst as header + payload + checksum and pushes every byte
// into the write side of the byte FIFO, stalling on full so nothing is dropped.
module fifo_pkt_writer
  import fifo_pkt_pkg::*;
(
  input  logic       wr_clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [3:0] len,
  input  logic       src_valid,
  input  logic [7:0] src_data,
  output logic       src_ready,
  input  logic       full,
  output logic       wr,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       done
);

  pkt_state_t state_q;
  logic [4:0] count_q;
  logic [4:0] len_q;
  logic [7:0] sum_q;
  logic       done_q;
  logic       xfer;

  // NOTE: every output gets a default before the case so no latch is inferred
  // for the states that do not drive it.
  always_comb begin
    src_ready = 1'b0;
    wr        = 1'b0;
    data_out  = 8'h00;
    unique case (state_q)
      HDR: begin
        data_out = {HDR_TAG, len_q[3:0]};
        wr       = !full;
      end
      PAY: begin
        src_ready = !full;
        wr        = src_valid & !full;
        data_out  = src_data;
      end
      CSUM: begin
        data_out = sum_q;
        wr       = !full;
      end
      default: ;
    endcase
  end

  assign xfer = src_valid & src_ready;
  assign busy = (state_q != IDLE);
  assign done = done_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge wr_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= 5'd0;
      sum_q   <= 8'h00;
      len_q   <= 5'd0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            len_q   <= decode_len(len);
            sum_q   <= 8'h00;
            count_q <= 5'd0;
            state_q <= HDR;
          end
        end
        HDR: begin
          if (wr) state_q <= PAY;
        end
        PAY: begin
          if (xfer) begin
            sum_q   <= sum_q + src_data;
            count_q <= count_q + 5'd1;
            if (count_q == len_q - 5'd1) state_q <= CSUM;
          end
        end
        CSUM: begin
          if (wr) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_pkt_writer.sv
// Scoreboard bench: expected FIFO bytes are queued when a frame is requested and
// checked by a negedge monitor each time the writer presents a FIFO write.
module tb_fifo_pkt_writer;

  logic       wr_clk;
  logic       reset_n;
  logic       start;
  logic [3:0] len;
  logic       src_valid;
  logic [7:0] src_data;
  logic       src_ready;
  logic       full;
  logic       wr;
  logic [7:0] data_out;
  logic       busy;
  logic       done;

  fifo_pkt_writer dut (
    .wr_clk   (wr_clk),
    .reset_n  (reset_n),
    .start    (start),
    .len      (len),
    .src_valid(src_valid),
    .src_data (src_data),
    .src_ready(src_ready),
    .full     (full),
    .wr       (wr),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  initial begin
    wr_clk = 1'b0;
    forever #5 wr_clk = ~wr_clk;
  end

  typedef struct {
    logic [7:0] data;
    bit         last;
  } sb_t;

  sb_t        sb_q[$];
  logic [7:0] pay_q[$];
  logic [7:0] fifo_q[$];
  int         pay_idx;
  int         rd_mode;     // 0 reader idle, 1 random drain, 2 drain every cycle
  bit         valid_rand;
  bit         noise_en;

  int n_tests = 0;
  int n_fail  = 0;

  logic       wr_s, xfer_s, busy_s, done_s;
  logic [7:0] data_s;
  logic       exp_done_q, prev_done_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: protocol checks every cycle, scoreboard pop on each FIFO write.
  always @(negedge wr_clk) begin : mon
    sb_t e;
    bit  nxt_done;
    if (!reset_n) begin
      wr_s        <= 1'b0;
      xfer_s      <= 1'b0;
      busy_s      <= 1'b0;
      done_s      <= 1'b0;
      exp_done_q  <= 1'b0;
      prev_done_q <= 1'b0;
    end else begin
      nxt_done = 1'b0;
      check("no_wr_when_full", wr & full, 0);
      check("no_ready_when_full", src_ready & full, 0);
      if (wr) begin
        check("sb_nonempty_on_wr", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("fifo_byte", data_out, e.data);
          nxt_done = e.last;
        end
      end
      check("done_pulse", done, exp_done_q);
      if (done) check("busy_in_done", busy, 1);
      if (prev_done_q) check("idle_after_done", busy, 0);
      exp_done_q  <= nxt_done;
      prev_done_q <= done;
      wr_s        <= wr;
      data_s      <= data_out;
      xfer_s      <= src_valid & src_ready;
      busy_s      <= busy;
      done_s      <= done;
    end
  end

  // One clock: update the FIFO occupancy model, the payload source and start noise.
  task automatic step();
    @(posedge wr_clk);
    #1;
    if (!reset_n) begin
      fifo_q.delete();
    end else begin
      if (rd_mode == 2 || (rd_mode == 1 && $urandom_range(0, 1) == 1))
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (wr_s) fifo_q.push_back(data_s);
    end
    full = (fifo_q.size() >= 8);
    if (xfer_s) pay_idx++;
    src_valid = (pay_idx < pay_q.size()) && (!valid_rand || $urandom_range(0, 2) != 0);
    src_data  = src_valid ? pay_q[pay_idx] : 8'($urandom);
    if (noise_en) begin
      start = busy_s && !done_s && ($urandom_range(0, 1) == 1);
      len   = 4'($urandom);
    end
  endtask

  // Queues the expected frame for the payload already in pay_q, then requests it.
  task automatic start_frame(input logic [3:0] l);
    int         n;
    logic [7:0] sum;
    n   = (l == 4'd0) ? 16 : int'(l);
    sum = 8'h00;
    sb_q.push_back('{data: {4'hA, l}, last: 1'b0});
    for (int i = 0; i < n; i++) begin
      sb_q.push_back('{data: pay_q[i], last: 1'b0});
      sum = sum + pay_q[i];
    end
    sb_q.push_back('{data: sum, last: 1'b1});
    pay_idx = 0;
    start   = 1'b1;
    len     = l;
    step();
    start = 1'b0;
    if (!full) check("hdr_latency", wr, 1);
  endtask

  task automatic wait_frame();
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 600) begin
      step();
      k++;
    end
    check("frame_complete", sb_q.size(), 0);
    sb_q.delete();
    noise_en = 1'b0;
    start    = 1'b0;
    step();
    step();
    check("idle_after_frame", busy, 0);
  endtask

  task automatic fill_payload(input int n, input bit fixed, input logic [7:0] val);
    pay_q.delete();
    for (int i = 0; i < n; i++) pay_q.push_back(fixed ? val : 8'($urandom));
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    len        = 4'd0;
    src_valid  = 1'b0;
    src_data   = 8'h00;
    full       = 1'b0;
    rd_mode    = 2;
    valid_rand = 1'b0;
    noise_en   = 1'b0;
    pay_idx    = 0;

    // Reset values
    repeat (3) step();
    check("rst_wr", wr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_src_ready", src_ready, 0);
    check("rst_data_out", data_out, 0);
    reset_n = 1'b1;
    step();
    check("idle_after_rst", busy, 0);

    // Basic frame: A3 01 02 03 06
    pay_q = '{8'h01, 8'h02, 8'h03};
    start_frame(4'd3);
    wait_frame();

    // len=0 means 16 bytes; sixteen 0x20 bytes wrap the checksum to 0x00
    rd_mode = 1;
    fill_payload(16, 1'b1, 8'h20);
    start_frame(4'd0);
    wait_frame();

    // Backpressure: 3 older entries + header + 4 payload fill the FIFO
    rd_mode = 0;
    fifo_q.delete();
    repeat (3) fifo_q.push_back(8'h55);
    fill_payload(4, 1'b0, 8'h00);
    start_frame(4'd4);
    for (int k = 0; k < 50 && !full; k++) step();
    check("bp_full_reached", full, 1);
    for (int k = 0; k < 10; k++) begin
      step();
      check("bp_wr_low", wr, 0);
      check("bp_ready_low", src_ready, 0);
    end
    rd_mode = 2;
    wait_frame();

    // start pulses while busy (including DONE) must be ignored
    rd_mode    = 1;
    valid_rand = 1'b1;
    fill_payload(9, 1'b0, 8'h00);
    start_frame(4'd9);
    noise_en = 1'b1;
    wait_frame();
    repeat (5) step();
    check("no_second_hdr", busy, 0);

    // Randomized frames with random source gaps, reader drain and start noise
    for (int f = 0; f < 8; f++) begin
      logic [3:0] l;
      l = 4'($urandom);
      fill_payload((l == 4'd0) ? 16 : int'(l), 1'b0, 8'h00);
      rd_mode = $urandom_range(1, 2);
      start_frame(l);
      noise_en = ($urandom_range(0, 1) == 1);
      wait_frame();
    end

    // Reset in the middle of the payload aborts the frame immediately
    rd_mode    = 2;
    valid_rand = 1'b0;
    fill_payload(5, 1'b0, 8'h00);
    start_frame(4'd5);
    for (int k = 0; k < 50 && pay_idx < 2; k++) step();
    check("mid_pay_reached", pay_idx, 2);
    #2 reset_n = 1'b0;
    #1;
    check("abort_wr", wr, 0);
    check("abort_busy", busy, 0);
    check("abort_src_ready", src_ready, 0);
    sb_q.delete();
    pay_q.delete();
    fifo_q.delete();
    src_valid = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
    check("idle_after_abort", busy, 0);

    // Fresh frame after reset: A1 FF FF
    pay_q = '{8'hFF};
    start_frame(4'd1);
    wait_frame();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
